// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask, one-cycle CPU pulse, EOI hold-off.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on irq_in for asynchronous sources.
module irq_ctrl #(
  parameter int N_IRQ   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             bus_sel,
  input  logic [2:0]       bus_addr,
  input  logic             bus_we,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             cpu_interrupt
);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SERVICE, S_GAP} state_t;

  state_t           state;
  logic [N_IRQ-1:0] pending, mask, irq_prev, irq_s;
  logic [N_IRQ-1:0] irq_edge, active, id_onehot, pend_set, pend_clr, wdata_n;
  logic [4:0]       id, next_id;
  logic [3:0]       gap_cnt;
  logic             wr, eoi, busy;
  logic             wdata_unused;

`ifdef IRQ_CTRL_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end
  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  assign wdata_n      = bus_wdata[N_IRQ-1:0];
  assign wdata_unused = ^bus_wdata[31:N_IRQ];
  assign wr       = bus_sel & bus_we;
  assign eoi      = wr && (bus_addr == 3'd3) && (state == S_SERVICE);
  assign irq_edge = irq_s & ~irq_prev;
  assign active   = pending & mask;
  assign busy     = (state == S_FIRE) || (state == S_SERVICE);

  // Sets are OR-ed in after clears so a coincident edge is never lost.
  assign pend_set = irq_edge | ((wr && bus_addr == 3'd4) ? wdata_n : '0);
  assign pend_clr = ((wr && bus_addr == 3'd0) ? wdata_n : '0) | (eoi ? id_onehot : '0);

  always_comb begin
    next_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) next_id = 5'(i);
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (id == 5'(i)) id_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pending       <= '0;
      mask          <= '0;
      irq_prev      <= '0;
      id            <= '0;
      gap_cnt       <= '0;
      cpu_interrupt <= 1'b0;
    end else begin
      irq_prev      <= irq_s;
      pending       <= (pending & ~pend_clr) | pend_set;
      cpu_interrupt <= 1'b0;
      if (wr && bus_addr == 3'd1) mask <= wdata_n;
      case (state)
        S_IDLE: begin
          if (|active) begin
            state         <= S_FIRE;
            id            <= next_id;
            cpu_interrupt <= 1'b1;
          end
        end
        S_FIRE: state <= S_SERVICE;
        S_SERVICE: begin
          if (eoi) begin
            if (GAP_CYC == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'(GAP_CYC - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      case (bus_addr)
        3'd0:    bus_rdata[N_IRQ-1:0] = pending;
        3'd1:    bus_rdata[N_IRQ-1:0] = mask;
        3'd2:    bus_rdata = {busy, 26'b0, id};
        default: bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl (default build, N_IRQ=8, GAP_CYC=2): vector table, corner sequences, random vs model.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_in;
  logic        bus_sel, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        cpu_interrupt;

  int checks = 0;
  int failures = 0;

  irq_ctrl #(.N_IRQ(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .cpu_interrupt(cpu_interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (phases: 0 idle, 1 pulse, 2 in service, 3 hold-off)
  bit [7:0]   m_pend, m_mask, m_prev;
  int         m_phase, m_gap, m_id;
  bit         sb_on = 1'b0;
  logic [4:0] exp_q[$];

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_phase = 0; m_gap = 0; m_id = 0;
  endtask

  task automatic model_step();
    bit [7:0] set_v, clr_v, act;
    bit       w;
    w     = bus_sel && bus_we;
    set_v = irq_in & ~m_prev;
    clr_v = 0;
    if (w && bus_addr == 4) set_v = set_v | bus_wdata[7:0];
    if (w && bus_addr == 0) clr_v = bus_wdata[7:0];
    if (w && bus_addr == 3 && m_phase == 2) clr_v[m_id] = 1'b1;
    act = m_pend & m_mask;
    if (m_phase == 0) begin
      if (act != 0) begin
        for (int i = 0; i < 8; i++) if (act[i]) begin m_id = i; break; end
        m_phase = 1;
        if (sb_on) exp_q.push_back(5'(m_id));
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (w && bus_addr == 3) begin m_phase = 3; m_gap = 2; end
    end else begin
      m_gap = m_gap - 1;
      if (m_gap == 0) m_phase = 0;
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    if (w && bus_addr == 1) m_mask = bus_wdata[7:0];
    m_prev = irq_in;
  endtask

  function automatic logic [31:0] model_rdata(input logic [2:0] a);
    case (a)
      3'd0: return {24'b0, m_pend};
      3'd1: return {24'b0, m_mask};
      3'd2: return {(m_phase == 1 || m_phase == 2), 26'b0, 5'(m_id)};
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver / checker tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic set_bus(input logic sel, input logic we, input logic [2:0] a, input logic [31:0] d);
    bus_sel = sel; bus_we = we; bus_addr = a; bus_wdata = d;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    set_bus(1'b1, 1'b0, a, 32'h0);
    #1;
    check(name, bus_rdata, exp);
  endtask

  task automatic wr_tick(input logic [2:0] a, input logic [31:0] d);
    set_bus(1'b1, 1'b1, a, d);
    tick();
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);
  endtask

  // Ticks until cpu_interrupt is seen; n = ticks taken, 0 if the bound expired.
  task automatic wait_pulse(input string name, input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (cpu_interrupt) begin n = i; break; end
    end
    if (n == 0) check({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  // ---------------- vector table
  typedef struct {
    logic [7:0]  irq;
    logic        sel, we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        exp_int;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] irq, input logic sel, input logic we,
                              input logic [2:0] a, input logic [31:0] d,
                              input logic ei, input logic [31:0] er);
    vec_t v;
    v.irq = irq; v.sel = sel; v.we = we; v.addr = a; v.wdata = d; v.exp_int = ei; v.exp_rdata = er;
    return v;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    irq_in = '0;
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);
    model_reset();

    // Single pulse on irq 2, then EOI and hold-off
    tbl.push_back(mk(8'h00, 1, 1, 3'd1, 32'h04, 0, 32'h0));
    tbl.push_back(mk(8'h04, 0, 0, 3'd0, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 1, 32'h8000_0002));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h04));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h8000_0002));
    tbl.push_back(mk(8'h00, 1, 1, 3'd3, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h2));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h2));
    // W1C with mask off
    tbl.push_back(mk(8'h00, 1, 1, 3'd1, 32'h00, 0, 32'h04));
    tbl.push_back(mk(8'h00, 1, 1, 3'd4, 32'h03, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h03));
    tbl.push_back(mk(8'h00, 1, 1, 3'd0, 32'h01, 0, 32'h03));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h02));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h2));
    // Masked SWSET then unmask
    tbl.push_back(mk(8'h00, 1, 1, 3'd0, 32'h02, 0, 32'h02));
    tbl.push_back(mk(8'h00, 1, 1, 3'd4, 32'h80, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h80));
    tbl.push_back(mk(8'h00, 1, 1, 3'd1, 32'h80, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h2));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 1, 32'h8000_0007));
    tbl.push_back(mk(8'h00, 1, 1, 3'd3, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h7));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h7));
    // EOI while idle is ignored
    tbl.push_back(mk(8'h00, 1, 1, 3'd1, 32'h00, 0, 32'h80));
    tbl.push_back(mk(8'h00, 1, 1, 3'd4, 32'h80, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 1, 3'd3, 32'h00, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 32'h00, 0, 32'h80));
    tbl.push_back(mk(8'h00, 1, 0, 3'd2, 32'h00, 0, 32'h7));
    // Unmapped offsets
    tbl.push_back(mk(8'h00, 1, 1, 3'd5, 32'hFFFF_FFFF, 0, 32'h0));
    tbl.push_back(mk(8'h00, 1, 0, 3'd1, 32'h00, 0, 32'h0));

    // ---------------- reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_int", {31'b0, cpu_interrupt}, 32'h0);
    read_chk("rst_pending", 3'd0, 32'h0);
    read_chk("rst_mask", 3'd1, 32'h0);
    read_chk("rst_status", 3'd2, 32'h0);
    bus_sel = 1'b0;
    #1;
    check("rdata_unselected", bus_rdata, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      irq_in = tbl[i].irq;
      set_bus(tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      #1;
      check($sformatf("vec%0d_int", i), {31'b0, cpu_interrupt}, {31'b0, tbl[i].exp_int});
      check($sformatf("vec%0d_rdata", i), bus_rdata, tbl[i].exp_rdata);
      tick();
    end
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);

    // ---------------- simultaneous edges: lowest index wins, second fires after hold-off
    wr_tick(3'd0, 32'h80);
    wr_tick(3'd1, 32'hFF);
    irq_in = 8'h22;
    tick();
    irq_in = 8'h00;
    tick();
    check("t2_pulse1", {31'b0, cpu_interrupt}, 32'h1);
    read_chk("t2_status1", 3'd2, 32'h8000_0001);
    tick();
    wr_tick(3'd3, 32'h0);
    read_chk("t2_pending_after_eoi", 3'd0, 32'h20);
    wait_pulse("t2_pulse2", 8, n);
    check("t2_gap_len", n, 3);
    read_chk("t2_status2", 3'd2, 32'h8000_0005);
    tick();
    wr_tick(3'd3, 32'h0);
    repeat (3) tick();

    // ---------------- new edge coincident with EOI for the same source
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    check("t3_pulse1", {31'b0, cpu_interrupt}, 32'h1);
    tick();
    irq_in = 8'h02;
    wr_tick(3'd3, 32'h0);
    irq_in = 8'h00;
    read_chk("t3_pending_kept", 3'd0, 32'h02);
    wait_pulse("t3_pulse2", 8, n);
    check("t3_gap_len", n, 3);
    read_chk("t3_status2", 3'd2, 32'h8000_0001);
    tick();
    wr_tick(3'd3, 32'h0);
    repeat (3) tick();

    // ---------------- reset during the pulse; a line high at release is an edge
    wr_tick(3'd4, 32'h10);
    tick();
    check("t5_pulse", {31'b0, cpu_interrupt}, 32'h1);
    irq_in = 8'h08;
    rst_n = 1'b0;
    #1;
    check("t5_reset_cut", {31'b0, cpu_interrupt}, 32'h0);
    read_chk("t5_pending", 3'd0, 32'h0);
    read_chk("t5_mask", 3'd1, 32'h0);
    read_chk("t5_status", 3'd2, 32'h0);
    model_reset();
    set_bus(1'b0, 1'b0, 3'd0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    read_chk("t5_edge_at_release", 3'd0, 32'h08);
    wr_tick(3'd0, 32'h08);
    read_chk("t5_no_reedge", 3'd0, 32'h00);
    irq_in = 8'h00;
    tick();

    // ---------------- randomized traffic against the model
    exp_q.delete();
    sb_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int r;
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      case (r)
        0, 1: set_bus(1'b1, 1'b1, 3'd3, $urandom);
        2:    set_bus(1'b1, 1'b1, 3'd1, $urandom);
        3:    set_bus(1'b1, 1'b1, 3'd0, $urandom);
        4:    set_bus(1'b1, 1'b1, 3'd4, $urandom & $urandom);
        5:    set_bus(1'b1, 1'b1, 3'($urandom_range(5, 7)), $urandom);
        6:    set_bus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        default: set_bus(1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'h0);
      endcase
      if (cpu_interrupt) set_bus(1'b1, 1'b0, 3'd2, 32'h0);
      #1;
      check("rnd_int", {31'b0, cpu_interrupt}, {31'b0, (m_phase == 1)});
      check("rnd_rdata", bus_rdata, bus_sel ? model_rdata(bus_addr) : 32'h0);
      if (cpu_interrupt) begin
        if (exp_q.size() == 0) check("rnd_unexpected_pulse", 32'h1, 32'h0);
        else check("rnd_pulse_id", {27'b0, bus_rdata[4:0]}, {27'b0, exp_q.pop_front()});
      end
      tick();
    end
    sb_on = 1'b0;
    check("rnd_missing_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
